// File: rtl/iir_coeff_ctl_if.sv
// Configuration write bus for the IIR coefficient controller.
// The master side issues one-cycle write strobes with an address and data word.
interface iir_coeff_ctl_if;
  logic        cfg_wr;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_data;

  modport master (
    output cfg_wr,
    output cfg_addr,
    output cfg_data
  );

  modport slave (
    input cfg_wr,
    input cfg_addr,
    input cfg_data
  );
endinterface

// File: rtl/iir_coeff_ctl.sv
// IIR coefficient controller.
// Generates the filter step and sample strobes from a free-running divider.
// Holds a shadow coefficient set written over the config bus. On a commit it
// waits for the next sample boundary, swaps the shadow set into the active
// outputs, then pulses filt_reset so the filter taps restart cleanly with the
// new coefficients. A commit that arrives while a swap is already in flight is
// remembered and replayed once the flush finishes.
module iir_coeff_ctl #(
  parameter int SAMPLE_DIV = 1024,
  parameter int FLUSH_CYC  = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  iir_coeff_ctl_if.slave cfg,
  output logic           ce,
  output logic           sample_ce,
  output logic [39:0]    cx,
  output logic [7:0]     cx0,
  output logic [7:0]     cx1,
  output logic [7:0]     cx2,
  output logic [23:0]    cy0,
  output logic [23:0]    cy1,
  output logic [23:0]    cy2,
  output logic           filt_reset,
  output logic           busy
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(SAMPLE_DIV / 2 - 1);
  localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_FLUSH
  } state_t;

  typedef struct packed {
    logic [39:0] cx;
    logic [7:0]  cx0;
    logic [7:0]  cx1;
    logic [7:0]  cx2;
    logic [23:0] cy0;
    logic [23:0] cy1;
    logic [23:0] cy2;
  } coeff_t;

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
  state_t           state_q, state_d;
  logic             pending_q, pending_d;
  coeff_t           shadow_q, shadow_d;
  coeff_t           active_q, active_d;
  logic             commit_req;

  // Sample-rate divider: wraps at the end of every sample period
  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (div_cnt_q == LAST_CNT) begin
      div_cnt_d = '0;
    end
  end

  assign sample_ce  = (div_cnt_q == LAST_CNT);
  assign ce         = (div_cnt_q == LAST_CNT) || (div_cnt_q == HALF_CNT);
  assign commit_req = cfg.cfg_wr && (cfg.cfg_addr == 4'd11);

  // Shadow register file: writes land here in any controller state
  always_comb begin
    shadow_d = shadow_q;
    if (cfg.cfg_wr) begin
      case (cfg.cfg_addr)
        4'd0:    shadow_d.cx[15:0]  = cfg.cfg_data;
        4'd1:    shadow_d.cx[31:16] = cfg.cfg_data;
        4'd2:    shadow_d.cx[39:32] = cfg.cfg_data[7:0];
        4'd3:    {shadow_d.cx1, shadow_d.cx0} = cfg.cfg_data;
        4'd4:    shadow_d.cx2       = cfg.cfg_data[7:0];
        4'd5:    shadow_d.cy0[15:0] = cfg.cfg_data;
        4'd6:    shadow_d.cy0[23:16] = cfg.cfg_data[7:0];
        4'd7:    shadow_d.cy1[15:0] = cfg.cfg_data;
        4'd8:    shadow_d.cy1[23:16] = cfg.cfg_data[7:0];
        4'd9:    shadow_d.cy2[15:0] = cfg.cfg_data;
        4'd10:   shadow_d.cy2[23:16] = cfg.cfg_data[7:0];
        default: shadow_d = shadow_q;
      endcase
    end
  end

  // Commit sequencing: wait for the sample boundary, swap, then flush the taps
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    flush_cnt_d = flush_cnt_q;
    active_d    = active_q;
    case (state_q)
      ST_IDLE: begin
        if (commit_req) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (commit_req) begin
          pending_d = 1'b1;
        end
        if (sample_ce) begin
          active_d    = shadow_q;
          flush_cnt_d = '0;
          state_d     = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (commit_req) begin
          pending_d = 1'b1;
        end
        if (flush_cnt_q == FC_LAST) begin
          if (pending_q || commit_req) begin
            pending_d = 1'b0;
            state_d   = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and data registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt_q   <= '0;
      flush_cnt_q <= '0;
      state_q     <= ST_IDLE;
      pending_q   <= 1'b0;
      shadow_q    <= '0;
      active_q    <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      state_q     <= state_d;
      pending_q   <= pending_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
    end
  end

  assign filt_reset = (state_q == ST_FLUSH);
  assign busy       = (state_q != ST_IDLE) || pending_q;

  assign cx  = active_q.cx;
  assign cx0 = active_q.cx0;
  assign cx1 = active_q.cx1;
  assign cx2 = active_q.cx2;
  assign cy0 = active_q.cy0;
  assign cy1 = active_q.cy1;
  assign cy2 = active_q.cy2;

endmodule

// File: tb/tb_iir_coeff_ctl.sv
// Testbench for iir_coeff_ctl.
// A register-file level model tracks the config words, the sample timeline and
// the outstanding commit work; every cycle the DUT outputs are compared with it.
// Directed scenarios add literal expectations at key points.
module tb_iir_coeff_ctl;

  localparam int SD = 1024;
  localparam int FC = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce, sample_ce, filt_reset, busy;
  logic [39:0] cx;
  logic [7:0]  cx0, cx1, cx2;
  logic [23:0] cy0, cy1, cy2;

  iir_coeff_ctl_if cfg_bus ();

  iir_coeff_ctl #(
    .SAMPLE_DIV (SD),
    .FLUSH_CYC  (FC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg        (cfg_bus),
    .ce         (ce),
    .sample_ce  (sample_ce),
    .cx         (cx),
    .cx0        (cx0),
    .cx1        (cx1),
    .cx2        (cx2),
    .cy0        (cy0),
    .cy1        (cy1),
    .cy2        (cy2),
    .filt_reset (filt_reset),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: position in the sample period, outstanding commit work,
  // and the written config words (shadow) and the words last swapped in.
  int          m_div = 0;
  bit          m_armed = 1'b0;
  bit          m_pending = 1'b0;
  int          m_flush_left = 0;
  logic [15:0] m_shadow [11];
  logic [15:0] m_active [11];
  bit          m_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model advanced once per clock edge
  always @(posedge clk) begin : model
    bit commit;
    bit arm;
    bit pend;
    int fl;
    if (!reset_n) begin
      m_div        <= 0;
      m_armed      <= 1'b0;
      m_pending    <= 1'b0;
      m_flush_left <= 0;
      for (int i = 0; i < 11; i++) begin
        m_shadow[i] <= 16'h0;
        m_active[i] <= 16'h0;
      end
    end else begin
      commit = cfg_bus.cfg_wr && (cfg_bus.cfg_addr == 4'd11);
      arm  = m_armed;
      pend = m_pending;
      fl   = m_flush_left;
      if (arm && (m_div == SD - 1)) begin
        m_active <= m_shadow;
        arm  = 1'b0;
        fl   = FC;
        pend = pend | commit;
      end else if (fl > 0) begin
        pend = pend | commit;
        fl   = fl - 1;
        if (fl == 0 && pend) begin
          pend = 1'b0;
          arm  = 1'b1;
        end
      end else if (arm) begin
        pend = pend | commit;
      end else if (commit) begin
        arm = 1'b1;
      end
      if (cfg_bus.cfg_wr && (cfg_bus.cfg_addr < 4'd11)) begin
        m_shadow[cfg_bus.cfg_addr] <= cfg_bus.cfg_data;
      end
      m_armed      <= arm;
      m_pending    <= pend;
      m_flush_left <= fl;
      m_div        <= (m_div + 1) % SD;
    end
    m_valid <= 1'b1;
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (m_valid) begin
      check("ce", ce, (m_div == SD - 1) || (m_div == SD / 2 - 1));
      check("sample_ce", sample_ce, m_div == SD - 1);
      check("filt_reset", filt_reset, m_flush_left > 0);
      check("busy", busy, m_armed || m_pending || (m_flush_left > 0));
      check("cx", cx, {m_active[2][7:0], m_active[1], m_active[0]});
      check("cx0", cx0, m_active[3][7:0]);
      check("cx1", cx1, m_active[3][15:8]);
      check("cx2", cx2, m_active[4][7:0]);
      check("cy0", cy0, {m_active[6][7:0], m_active[5]});
      check("cy1", cy1, {m_active[8][7:0], m_active[7]});
      check("cy2", cy2, {m_active[10][7:0], m_active[9]});
    end
  end

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
    cfg_bus.cfg_wr   = 1'b1;
    cfg_bus.cfg_addr = a;
    cfg_bus.cfg_data = d;
    @(posedge clk);
    #1;
    cfg_bus.cfg_wr = 1'b0;
  endtask

  task automatic goto_div(input int d);
    for (int n = 0; n < 2 * SD && m_div != d; n++) begin
      @(posedge clk);
      #1;
    end
    check("goto_div_reached", m_div, d);
  endtask

  // Hold reset while issuing writes that must be ignored, then release
  task automatic apply_reset(input bit after_flush);
    reset_n = 1'b0;
    cfg_write(4'd0, 16'hFFFF);
    if (after_flush) begin
      @(negedge clk);
      check("rst_filt_reset", filt_reset, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_cx", cx, 40'h0);
      check("rst_cy1", cy1, 24'h0);
    end
    cfg_write(4'd11, 16'h0);
    cfg_write(4'd2, 16'hFFFF);
    reset_n = 1'b1;
  endtask

  // Count cycles from reset release to the first ce and sample_ce
  task automatic measure_first();
    int ce_cyc;
    int sc_cyc;
    ce_cyc = 0;
    sc_cyc = 0;
    for (int n = 1; n <= 2 * SD; n++) begin
      @(negedge clk);
      if (ce && ce_cyc == 0) ce_cyc = n;
      if (sample_ce) begin
        sc_cyc = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("first_ce_cycle", ce_cyc, 512);
    check("first_sample_ce_cycle", sc_cyc, 1024);
    check("ce_with_sample_ce", ce, 1'b1);
  endtask

  initial begin
    cfg_bus.cfg_wr   = 1'b0;
    cfg_bus.cfg_addr = 4'd0;
    cfg_bus.cfg_data = 16'h0;

    apply_reset(1'b0);
    measure_first();

    // Unmapped addresses must not reach the shadow set
    goto_div(2);
    for (int a = 12; a < 16; a++) cfg_write(4'(a), 16'hFFFF);
    cfg_write(4'd11, 16'h0);
    goto_div(0);
    @(negedge clk);
    check("unmapped_swap_cx", cx, 40'h0);
    check("unmapped_swap_cy2", cy2, 24'h0);
    check("unmapped_swap_filt", filt_reset, 1'b1);

    // Full coefficient load and commit
    goto_div(10);
    for (int i = 0; i < 11; i++) cfg_write(4'(i), 16'(16'h1111 * (i + 1)));
    goto_div(100);
    cfg_write(4'd11, 16'h0);
    goto_div(500);
    @(negedge clk);
    check("wait_cx_unchanged", cx, 40'h0);
    check("wait_busy", busy, 1'b1);
    goto_div(1023);
    @(negedge clk);
    check("swap_cycle_cx_old", cx, 40'h0);
    goto_div(0);
    @(negedge clk);
    check("lit_cx", cx, 40'h33_2222_1111);
    check("lit_cx0", cx0, 8'h44);
    check("lit_cx1", cx1, 8'h44);
    check("lit_cx2", cx2, 8'h55);
    check("lit_cy0", cy0, 24'h77_6666);
    check("lit_cy1", cy1, 24'h99_8888);
    check("lit_cy2", cy2, 24'hBB_AAAA);
    check("lit_filt_high", filt_reset, 1'b1);
    goto_div(4);
    @(negedge clk);
    check("after_flush_filt", filt_reset, 1'b0);
    check("after_flush_busy", busy, 1'b0);

    // Write on the swap cycle plus repeated commits during flush
    goto_div(50);
    cfg_write(4'd0, 16'hA0A0);
    goto_div(100);
    cfg_write(4'd11, 16'h0);
    goto_div(1023);
    cfg_write(4'd5, 16'hBEEF);
    cfg_write(4'd11, 16'h0);
    cfg_write(4'd11, 16'h0);
    @(negedge clk);
    check("swap2_cx", cx, 40'h33_2222_A0A0);
    check("swap2_cy0_old", cy0, 24'h77_6666);
    check("swap2_busy", busy, 1'b1);
    goto_div(10);
    @(negedge clk);
    check("pending_rewait_busy", busy, 1'b1);
    check("pending_rewait_filt", filt_reset, 1'b0);
    goto_div(1023);
    @(negedge clk);
    check("pending_cy0_before", cy0, 24'h77_6666);
    goto_div(0);
    @(negedge clk);
    check("swap3_cy0", cy0, 24'h77_BEEF);
    check("swap3_filt", filt_reset, 1'b1);
    goto_div(10);
    @(negedge clk);
    check("swap3_single_busy", busy, 1'b0);

    // Reset in the middle of a flush
    goto_div(20);
    cfg_write(4'd7, 16'h1234);
    cfg_write(4'd11, 16'h0);
    goto_div(1023);
    goto_div(0);
    @(negedge clk);
    check("swap4_cy1", cy1, 24'h99_1234);
    goto_div(1);
    apply_reset(1'b1);
    measure_first();

    // Commit after reset delivers the cleared shadow set
    goto_div(20);
    cfg_write(4'd11, 16'h0);
    goto_div(1023);
    goto_div(0);
    @(negedge clk);
    check("post_reset_cx", cx, 40'h0);
    check("post_reset_cy1", cy1, 24'h0);
    check("post_reset_filt", filt_reset, 1'b1);
    goto_div(8);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Run-time guard so the bench always ends
  initial begin
    #(1_000_000);
    failures++;
    $display("[TB] FAIL timeout at t=%0t: got running expected finished", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/iir_coeff_ctl.md
IIR_COEFF_CTL -- requirements
Module: iir_coeff_ctl

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 1024, meaning clocks per output sample period; even, >= 8.
REQ-002 SHALL have parameter FLUSH_CYC, default 4, meaning filter-reset pulse length in clocks; 1 .. SAMPLE_DIV/2-2.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port cfg_wr  input  1  one-cycle config write strobe.
REQ-006 SHALL have port cfg_addr  input  4  config register address.
REQ-007 SHALL have port cfg_data  input  16  config write data.
REQ-008 SHALL have port ce  output  1  filter step strobe, two per sample period (stereo rate).
REQ-009 SHALL have port sample_ce  output  1  output sample strobe, one per sample period.
REQ-010 SHALL have ports cx (40), cx0/cx1/cx2 (8 each), cy0/cy1/cy2 (24 each)  output  active coefficient set for the filter's port-driven mode.
REQ-011 SHALL have port filt_reset  output  1  active-high clear of filter tap state.
REQ-012 SHALL have port busy  output  1  commit in progress or pending.

Function
REQ-013 SHALL keep a free-running counter div_cnt 0..SAMPLE_DIV-1, wrapping to 0.
REQ-014 SHALL assert sample_ce for exactly the cycles where div_cnt == SAMPLE_DIV-1.
REQ-015 SHALL assert ce for exactly the cycles where div_cnt == SAMPLE_DIV-1 or div_cnt == SAMPLE_DIV/2-1.
REQ-016 SHALL map cfg_wr writes into shadow registers: 0 cx[15:0]; 1 cx[31:16]; 2 cx[39:32]=data[7:0]; 3 {cx1,cx0}=data; 4 cx2=data[7:0]; 5 cy0[15:0]; 6 cy0[23:16]=data[7:0]; 7 cy1[15:0]; 8 cy1[23:16]; 9 cy2[15:0]; 10 cy2[23:16]; 11 commit request (data ignored); 12-15 ignored.
REQ-017 SHALL accept shadow writes in every state; active outputs change only at a swap.
REQ-018 SHALL implement FSM IDLE -> WAIT (on commit request) -> FLUSH (on sample_ce in WAIT) -> IDLE (after FLUSH_CYC cycles).
REQ-019 SHALL, on the WAIT cycle with sample_ce high, copy all shadow registers to active outputs, visible the next cycle.
REQ-020 SHALL drive filt_reset high for exactly FLUSH_CYC cycles, starting the cycle after the swap.
REQ-021 SHALL, on a commit request while not IDLE, set a pending flag; on entering IDLE with pending set, clear it and go to WAIT in the same cycle.
REQ-022 SHALL apply a shadow write coinciding with the swap cycle to shadow only; the swap copies pre-write shadow contents.
REQ-023 SHALL treat multiple commit requests while pending as one.
REQ-024 SHALL assert busy whenever state != IDLE or pending is set (registered, combinational decode allowed).
REQ-025 SHALL never assert filt_reset on a cycle where ce is high (guaranteed by REQ-002 range).

Reset
REQ-026 SHALL, while reset_n is low at a clock edge: div_cnt=0, state=IDLE, pending=0, all shadow and active coefficients=0, filt_reset=0, busy=0, ce=0, sample_ce=0.
REQ-027 SHALL abort any WAIT/FLUSH on reset mid-operation, with no swap and filt_reset dropping the next cycle.
REQ-028 SHALL ignore cfg_wr while reset_n is low.

Verification
REQ-029 Free-run after reset, SAMPLE_DIV=1024 -> first sample_ce in cycle 1024 after release, ce in cycles 512 and 1024, period 1024/512 thereafter.
REQ-030 Write addr 0..10 with 0x1111..0xBBBB, commit at div_cnt=100 -> outputs unchanged until the sample_ce at div_cnt=1023; next cycle cx=0x33_2222_1111, cx0=0x44, cx1=0x44, cx2=0x55, cy0=0x77_6666, cy1=0x99_8888, cy2=0xBB_AAAA; filt_reset high 4 cycles; busy low after.
REQ-031 Second commit during FLUSH -> pending set, busy stays high, re-enter WAIT on IDLE entry, second swap at next sample_ce.
REQ-032 Write addr 5 = 0xBEEF on the swap cycle -> active cy0[15:0] keeps old value; following commit delivers 0xBEEF.
REQ-033 reset_n low during FLUSH -> filt_reset low next cycle, all coefficients 0, busy 0, div_cnt restarts at 0.
REQ-034 Writes to addr 12-15 and cfg_wr during reset -> no shadow or active change.
